// File: rtl/switch_word_loader_pkg.sv
// Shared types and constants for the switch word loader: FSM state encoding,
// byte/word widths and the seven-segment codes used to show the state on HEX.
package loader_pkg;

    localparam int LOADER_WORD_W = 16;
    localparam int LOADER_BYTE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_LO    = 3'd2,
        S_HI    = 3'd3,
        S_WRITE = 3'd4,
        S_FULL  = 3'd5
    } loader_state_t;

    // Active-low seven-segment patterns {g,f,e,d,c,b,a} showing the state number
    localparam logic [6:0] HEX_S_IDLE  = 7'b1000000;
    localparam logic [6:0] HEX_S_ADDR  = 7'b1111001;
    localparam logic [6:0] HEX_S_LO    = 7'b0100100;
    localparam logic [6:0] HEX_S_HI    = 7'b0110000;
    localparam logic [6:0] HEX_S_WRITE = 7'b0011001;
    localparam logic [6:0] HEX_S_FULL  = 7'b0010010;
    localparam logic [6:0] HEX_BLANK   = 7'b1111111;

    function automatic logic [6:0] loader_state_hex(input logic [2:0] code);
        case (code)
            3'd0:    return HEX_S_IDLE;
            3'd1:    return HEX_S_ADDR;
            3'd2:    return HEX_S_LO;
            3'd3:    return HEX_S_HI;
            3'd4:    return HEX_S_WRITE;
            3'd5:    return HEX_S_FULL;
            default: return HEX_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/switch_word_loader_if.sv
// Memory write port of the switch word loader: a req/ack handshake carrying
// address and 16-bit data towards the memory write arbiter.
interface switch_word_loader_if
    import loader_pkg::*;
#(
    parameter int ADDR_W = 7
);
    logic                     mem_req;
    logic                     mem_ack;
    logic [ADDR_W-1:0]        mem_addr;
    logic [LOADER_WORD_W-1:0] mem_wdata;

    modport master (
        output mem_req,
        output mem_addr,
        output mem_wdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack
    );
endinterface

// File: rtl/switch_word_loader.sv
// Keys 16-bit words into memory from the board switches: start address, then
// low/high byte per word, each written via req/ack. LOADER_CHECKSUM_EN adds a running sum.
module switch_word_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     strobe,
    input  logic [LOADER_BYTE_W-1:0] sw_data,
    switch_word_loader_if.master     mem,
    output logic [ADDR_W:0]          word_count,
    output logic                     full,
    output logic [2:0]               state,
    output logic [LOADER_WORD_W-1:0] checksum
);

    generate
        if (ADDR_W < 1 || ADDR_W > 8) begin : g_bad_addr_w
            $error("switch_word_loader: ADDR_W must be in 1..8");
        end
    endgenerate

    localparam logic [ADDR_W-1:0] ADDR_TOP = '1;
    localparam logic [ADDR_W:0]   WC_MAX   = {1'b1, {ADDR_W{1'b0}}};

    loader_state_t            state_reg, state_next;
    logic                     mem_req_reg;
    logic [ADDR_W-1:0]        addr_reg;
    logic [LOADER_WORD_W-1:0] wdata_reg;
    logic [ADDR_W:0]          word_count_reg;
    logic                     write_done;
    logic                     enter_addr;

    assign write_done = (state_reg == S_WRITE) && mem.mem_ack;
    assign enter_addr = (state_reg == S_IDLE) && (state_next == S_ADDR);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (enable) state_next = S_ADDR;
            S_ADDR:  if (!enable) state_next = S_IDLE;
                     else if (strobe) state_next = S_LO;
            S_LO:    if (!enable) state_next = S_IDLE;
                     else if (strobe) state_next = S_HI;
            S_HI:    if (!enable) state_next = S_IDLE;
                     else if (strobe) state_next = S_WRITE;
            // An enable drop waits for the ack; the request is never abandoned
            S_WRITE: if (mem.mem_ack) begin
                         if (!enable)                  state_next = S_IDLE;
                         else if (addr_reg == ADDR_TOP) state_next = S_FULL;
                         else                           state_next = S_LO;
                     end
            S_FULL:  if (!enable) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            mem_req_reg    <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            word_count_reg <= '0;
        end else begin
            state_reg   <= state_next;
            mem_req_reg <= (state_next == S_WRITE);

            if (enter_addr)
                word_count_reg <= '0;
            else if (write_done && word_count_reg != WC_MAX)
                word_count_reg <= word_count_reg + 1'b1;

            // The top address is held so the display shows where memory filled
            if (state_reg == S_ADDR && enable && strobe)
                addr_reg <= sw_data[ADDR_W-1:0];
            else if (write_done && addr_reg != ADDR_TOP)
                addr_reg <= addr_reg + 1'b1;

            if (state_reg == S_LO && enable && strobe)
                wdata_reg[LOADER_BYTE_W-1:0] <= sw_data;
            if (state_reg == S_HI && enable && strobe)
                wdata_reg[LOADER_WORD_W-1:LOADER_BYTE_W] <= sw_data;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [LOADER_WORD_W-1:0] checksum_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            checksum_reg <= '0;
        else if (enter_addr)
            checksum_reg <= '0;
        else if (write_done)
            checksum_reg <= checksum_reg + wdata_reg;
    end

    assign checksum = checksum_reg;
`else
    assign checksum = '0;
`endif

    assign mem.mem_req   = mem_req_reg;
    assign mem.mem_addr  = addr_reg;
    assign mem.mem_wdata = wdata_reg;
    assign word_count    = word_count_reg;
    assign full          = (state_reg == S_FULL);
    assign state         = state_reg;

endmodule

// File: tb/tb_switch_word_loader.sv
// Scoreboard bench for switch_word_loader: expected writes are queued by the
// stimulus and checked by a monitor on each accepted req/ack handshake.
module tb_switch_word_loader;
    import loader_pkg::*;

    localparam int ADDR_W = 7;

    logic              clk;
    logic              rst;
    logic              enable;
    logic              strobe;
    logic [7:0]        sw_data;
    logic [ADDR_W:0]   word_count;
    logic              full;
    logic [2:0]        state;
    logic [15:0]       checksum;

    switch_word_loader_if #(.ADDR_W(ADDR_W)) mif ();

    switch_word_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .strobe     (strobe),
        .sw_data    (sw_data),
        .mem        (mif),
        .word_count (word_count),
        .full       (full),
        .state      (state),
        .checksum   (checksum)
    );

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    // Memory-side responder controls
    bit  resp_en   = 1'b0;
    int  ack_delay = 0;
    bit  pulse_req = 1'b0;
    int  wait_cnt  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_byte(input logic [7:0] b);
        sw_data = b;
        strobe  = 1'b1;
        tick();
        strobe  = 1'b0;
    endtask

    task automatic push_write(input logic [7:0] a, input logic [15:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic wait_done(input string name);
        int i;
        i = 0;
        while (mif.mem_req && i < 40) begin
            tick();
            i++;
        end
        check(name, {31'd0, mif.mem_req}, 32'd0);
    endtask

    // Responder: acks a pending request after ack_delay cycles, holds ack one cycle
    initial begin
        mif.mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (pulse_req) begin
                mif.mem_ack = 1'b1;
                pulse_req   = 1'b0;
            end else if (mif.mem_ack) begin
                mif.mem_ack = 1'b0;
                wait_cnt    = 0;
            end else if (resp_en && mif.mem_req) begin
                if (wait_cnt >= ack_delay) begin
                    mif.mem_ack = 1'b1;
                    wait_cnt    = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: every accepted handshake must match the head of the queue
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && mif.mem_req && mif.mem_ack) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL write_unexpected: got addr 0x%0h data 0x%0h, expected no write",
                             mif.mem_addr, mif.mem_wdata);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    if ({1'b0, mif.mem_addr} !== w.addr || mif.mem_wdata !== w.data) begin
                        n_fail++;
                        $display("FAIL write: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                                 mif.mem_addr, mif.mem_wdata, w.addr, w.data);
                    end else begin
                        $display("ok   write: addr 0x%0h data 0x%0h", w.addr, w.data);
                    end
                end
            end
        end
    end

    initial begin
        logic [15:0] exp_cs;
        rst     = 1'b1;
        enable  = 1'b0;
        strobe  = 1'b0;
        sw_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check("reset_state",    {29'd0, state}, 32'd0);
        check("reset_req",      {31'd0, mif.mem_req}, 32'd0);
        check("reset_addr",     {25'd0, mif.mem_addr}, 32'd0);
        check("reset_wcount",   {24'd0, word_count}, 32'd0);
        check("reset_full",     {31'd0, full}, 32'd0);
        check("reset_checksum", {16'd0, checksum}, 32'd0);

        // Entry with a 3-cycle ack stall and a strobe dropped during the write
        strobe_byte(8'h01);
        check("idle_ignores_strobe", {29'd0, state}, 32'd0);
        enable = 1'b1;
        tick();
        check("enter_addr_state", {29'd0, state}, 32'd1);
        resp_en   = 1'b1;
        ack_delay = 3;
        push_write(8'h10, 16'h1234);
        strobe_byte(8'h10);
        check("addr_captured", {25'd0, mif.mem_addr}, 32'h10);
        check("lo_state", {29'd0, state}, 32'd2);
        strobe_byte(8'h34);
        check("hi_state", {29'd0, state}, 32'd3);
        strobe_byte(8'h12);
        check("req_latency", {31'd0, mif.mem_req}, 32'd1);
        check("write_state", {29'd0, state}, 32'd4);
        strobe_byte(8'h55);
        check("stall_addr",  {25'd0, mif.mem_addr}, 32'h10);
        check("stall_wdata", {16'd0, mif.mem_wdata}, 32'h1234);
        check("stall_state", {29'd0, state}, 32'd4);
        wait_done("write1_done");
        check("post_addr",   {25'd0, mif.mem_addr}, 32'h11);
        check("post_wcount", {24'd0, word_count}, 32'd1);
        check("post_state",  {29'd0, state}, 32'd2);

        // Ack pulse in S_LO is ignored; then abort after the low byte
        pulse_req = 1'b1;
        tick();
        tick();
        check("lo_ack_state",  {29'd0, state}, 32'd2);
        check("lo_ack_addr",   {25'd0, mif.mem_addr}, 32'h11);
        check("lo_ack_wcount", {24'd0, word_count}, 32'd1);
        strobe_byte(8'hAA);
        check("lo_byte", {24'd0, mif.mem_wdata[7:0]}, 32'hAA);
        enable = 1'b0;
        tick();
        check("abort_state",  {29'd0, state}, 32'd0);
        check("abort_req",    {31'd0, mif.mem_req}, 32'd0);
        check("abort_wcount", {24'd0, word_count}, 32'd1);
        check("abort_addr",   {25'd0, mif.mem_addr}, 32'h11);

        // Checksum session; enable drops during the second write
        enable = 1'b1;
        tick();
        check("reentry_wcount", {24'd0, word_count}, 32'd0);
        ack_delay = 1;
        push_write(8'h20, 16'hFFFF);
        strobe_byte(8'h20);
        strobe_byte(8'hFF);
        strobe_byte(8'hFF);
        wait_done("write2_done");
        check("write2_state", {29'd0, state}, 32'd2);
        ack_delay = 2;
        push_write(8'h21, 16'h0002);
        strobe_byte(8'h02);
        strobe_byte(8'h00);
        enable = 1'b0;
        tick();
        check("defer_state", {29'd0, state}, 32'd4);
        check("defer_req",   {31'd0, mif.mem_req}, 32'd1);
        wait_done("write3_done");
        check("defer_idle",   {29'd0, state}, 32'd0);
        check("defer_wcount", {24'd0, word_count}, 32'd2);
`ifdef LOADER_CHECKSUM_EN
        exp_cs = 16'h0001;
`else
        exp_cs = 16'h0000;
`endif
        check("checksum", {16'd0, checksum}, {16'd0, exp_cs});

        // Wrap at the top address with an immediate ack
        enable = 1'b1;
        tick();
        ack_delay = 0;
        push_write(8'h7F, 16'hBEEF);
        strobe_byte(8'h7F);
        strobe_byte(8'hEF);
        strobe_byte(8'hBE);
        wait_done("write4_done");
        check("full_state",  {29'd0, state}, 32'd5);
        check("full_flag",   {31'd0, full}, 32'd1);
        check("full_addr",   {25'd0, mif.mem_addr}, 32'h7F);
        check("full_wcount", {24'd0, word_count}, 32'd1);
        strobe_byte(8'h01);
        strobe_byte(8'h02);
        tick();
        check("full_no_req",   {31'd0, mif.mem_req}, 32'd0);
        check("full_hold",     {29'd0, state}, 32'd5);
        enable = 1'b0;
        tick();
        check("full_exit_state", {29'd0, state}, 32'd0);
        check("full_exit_flag",  {31'd0, full}, 32'd0);

        // Strobe coincident with an enable fall in S_ADDR
        enable = 1'b1;
        tick();
        enable  = 1'b0;
        sw_data = 8'h33;
        strobe  = 1'b1;
        tick();
        strobe  = 1'b0;
        check("coincide_state", {29'd0, state}, 32'd0);
        check("coincide_addr",  {25'd0, mif.mem_addr}, 32'h7F);

        // Asynchronous reset while a request is outstanding
        enable  = 1'b1;
        resp_en = 1'b0;
        tick();
        strobe_byte(8'h05);
        strobe_byte(8'h11);
        strobe_byte(8'h22);
        tick();
        check("prereset_req", {31'd0, mif.mem_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_req",    {31'd0, mif.mem_req}, 32'd0);
        check("async_state",  {29'd0, state}, 32'd0);
        check("async_addr",   {25'd0, mif.mem_addr}, 32'd0);
        check("async_wcount", {24'd0, word_count}, 32'd0);
        enable = 1'b0;
        tick();
        rst = 1'b0;
        repeat (3) tick();

        check("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
